// File: rtl/sample_seq_pkg.sv
// ---------------------------------------------------------------------------
// sample_seq_pkg
// Shared constants and the sequencer state type for the sample_seq block.
//   DATA_W     : sample width (Q6.9 fixed point, value = real*512)
//   ADDR_W     : sample memory address width
//   DEPTH      : number of valid memory locations
//   EPOCH_W    : width of the epoch counter / num_epochs port
//   FIFO_DEPTH : entries in the tagged output buffer
//   state_t    : sequencer FSM states
// ---------------------------------------------------------------------------
package sample_seq_pkg;

    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 11;
    localparam int DEPTH      = 1024;
    localparam int EPOCH_W    = 8;
    localparam int FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/sample_seq_fifo2.sv
// ---------------------------------------------------------------------------
// sample_seq_fifo2
// Two-entry FIFO holding read data together with its index/last/epoch tag.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (clears storage too)
//   flush      : empties the FIFO on the next edge (storage left untouched)
//   push       : write push_data (accepted when not full, or full and popping)
//   push_data  : tagged entry to write
//   pop        : remove the head entry (ignored when empty)
//   head_data  : current head entry
//   count      : number of valid entries (0..2)
// ---------------------------------------------------------------------------
module sample_seq_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic [1:0]   count
);
    import sample_seq_pkg::*;

    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;
    logic         w_do_push;
    logic         w_do_pop;
    logic [W-1:0] w_entry [FIFO_DEPTH];

    assign w_do_pop  = pop && (r_count != 2'd0);
    // A push into a full buffer is legal only when the head leaves the same cycle.
    assign w_do_push = push && !flush && ((r_count != 2'd2) || w_do_pop);

    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            logic [W-1:0] r_data;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_data <= '0;
                end else if (w_do_push && (r_wr_ptr == 1'(gi))) begin
                    r_data <= push_data;
                end
            end
            assign w_entry[gi] = r_data;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_do_pop)  r_rd_ptr <= ~r_rd_ptr;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head_data = w_entry[r_rd_ptr];
    assign count     = r_count;

endmodule

// File: rtl/sample_seq.sv
// ---------------------------------------------------------------------------
// sample_seq
// Reads sample pairs (x1, x2) from two read-only memories in address order,
// num_samples per epoch for num_epochs epochs, and streams them out through a
// valid/ready handshake tagged with index, last-of-epoch and epoch number.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   start, abort          : begin a run (IDLE only) / terminate a run
//   num_samples           : samples per epoch (clamped to DEPTH), sampled on start
//   num_epochs            : epochs per run, sampled on start
//   mem_ena, wr_rd, addr  : memory read request (wr_rd always 0)
//   x1_rdata, x2_rdata    : memory data, valid one cycle after mem_ena
//   s_valid, s_ready      : output handshake
//   s_x1, s_x2            : output sample pair
//   s_idx, s_last, s_epoch: sample index, final-of-epoch flag, epoch number
//   busy, done            : not IDLE / one-cycle completion pulse
// ---------------------------------------------------------------------------
module sample_seq #(
    parameter int DATA_W = sample_seq_pkg::DATA_W,
    parameter int ADDR_W = sample_seq_pkg::ADDR_W,
    parameter int DEPTH  = sample_seq_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] num_samples,
    input  logic [7:0]        num_epochs,
    output logic              mem_ena,
    output logic              wr_rd,
    output logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] x1_rdata,
    input  logic [DATA_W-1:0] x2_rdata,
    output logic              s_valid,
    input  logic              s_ready,
    output logic [DATA_W-1:0] s_x1,
    output logic [DATA_W-1:0] s_x2,
    output logic [ADDR_W-1:0] s_idx,
    output logic              s_last,
    output logic [7:0]        s_epoch,
    output logic              busy,
    output logic              done
);
    import sample_seq_pkg::*;

    localparam int                ENT_W   = 2*DATA_W + ADDR_W + 1 + 8;
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_last_addr;
    logic [7:0]        r_epoch;
    logic [7:0]        r_last_epoch;
    logic              r_all_issued;
    logic              r_done;
    logic              r_pend;
    logic [ADDR_W-1:0] r_pend_idx;
    logic              r_pend_last;
    logic [7:0]        r_pend_epoch;

    logic [ADDR_W-1:0] w_ns_clamp;
    logic [ADDR_W-1:0] w_cur_last_addr;
    logic [7:0]        w_cur_last_epoch;
    logic              w_start_ok;
    logic              w_nonzero;
    logic              w_pop;
    logic [2:0]        w_occ;
    logic              w_credit;
    logic              w_issue;
    logic              w_tag_last;
    logic              w_final;
    logic [1:0]        w_fifo_count;
    logic [ENT_W-1:0]  w_push_data;
    logic [ENT_W-1:0]  w_head;

    assign w_ns_clamp = (num_samples > DEPTH_A) ? DEPTH_A : num_samples;
    assign w_nonzero  = (w_ns_clamp != '0) && (num_epochs != 8'd0);
    assign w_start_ok = (r_state == ST_IDLE) && start && !abort && !rst;

    // The first read goes out in the start cycle itself, before the run
    // bounds are latched, so the tag comparisons use the live port values
    // while in IDLE.
    assign w_cur_last_addr  = (r_state == ST_IDLE) ? (w_ns_clamp - ADDR_W'(1)) : r_last_addr;
    assign w_cur_last_epoch = (r_state == ST_IDLE) ? (num_epochs - 8'd1)       : r_last_epoch;

    // Entries that will occupy the buffer once this cycle's pop and the
    // in-flight capture settle; a new read is only safe if one slot remains.
    assign w_pop    = s_valid && s_ready;
    assign w_occ    = {1'b0, w_fifo_count} + {2'b00, r_pend} - {2'b00, w_pop};
    assign w_credit = (w_occ < 3'd2);

    assign w_issue = !abort && !rst &&
                     ((w_start_ok && w_nonzero) ||
                      ((r_state == ST_RUN) && !r_all_issued && w_credit));

    assign w_tag_last = (r_addr == w_cur_last_addr);
    assign w_final    = w_tag_last && (r_epoch == w_cur_last_epoch);

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_last_addr  <= '0;
            r_epoch      <= '0;
            r_last_epoch <= '0;
            r_all_issued <= 1'b0;
            r_done       <= 1'b0;
            r_pend       <= 1'b0;
            r_pend_idx   <= '0;
            r_pend_last  <= 1'b0;
            r_pend_epoch <= '0;
        end else begin
            r_done <= (r_state == ST_DONE);
            r_pend <= w_issue;
            if (w_issue) begin
                r_pend_idx   <= r_addr;
                r_pend_last  <= w_tag_last;
                r_pend_epoch <= r_epoch;
                r_addr       <= w_tag_last ? '0 : (r_addr + ADDR_W'(1));
                if (w_tag_last) begin
                    r_epoch <= w_final ? 8'd0 : (r_epoch + 8'd1);
                end
                if (w_final) begin
                    r_all_issued <= 1'b1;
                end
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        r_last_addr  <= w_ns_clamp - ADDR_W'(1);
                        r_last_epoch <= num_epochs - 8'd1;
                        r_state      <= w_nonzero ? ST_RUN : ST_DONE;
                    end
                end
                ST_RUN: begin
                    // r_all_issued covers a run whose only read left in the start cycle.
                    if (r_all_issued || (w_issue && w_final)) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if ((w_fifo_count == 2'd0) && !r_pend) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_all_issued <= 1'b0;
                    r_state      <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_push_data = {x1_rdata, x2_rdata, r_pend_idx, r_pend_last, r_pend_epoch};

    sample_seq_fifo2 #(
        .W (ENT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (abort),
        .push      (r_pend),
        .push_data (w_push_data),
        .pop       (w_pop),
        .head_data (w_head),
        .count     (w_fifo_count)
    );

    assign {s_x1, s_x2, s_idx, s_last, s_epoch} = w_head;

    assign s_valid = (w_fifo_count != 2'd0);
    assign mem_ena = w_issue;
    assign wr_rd   = 1'b0;
    assign addr    = r_addr;
    assign busy    = (r_state != ST_IDLE);
    assign done    = r_done;

endmodule

// File: tb/tb_sample_seq.sv
// ---------------------------------------------------------------------------
// tb_sample_seq
// Directed bench for sample_seq: a table of run configurations driven through
// one run task with a memory model and expected-sequence model, plus
// hand-written abort, start+abort and mid-run reset sequences.
// ---------------------------------------------------------------------------
module tb_sample_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [10:0] num_samples;
    logic [7:0]  num_epochs;
    logic        mem_ena;
    logic        wr_rd;
    logic [10:0] addr;
    logic [15:0] x1_rdata;
    logic [15:0] x2_rdata;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_x1;
    logic [15:0] s_x2;
    logic [10:0] s_idx;
    logic        s_last;
    logic [7:0]  s_epoch;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    sample_seq dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .num_samples (num_samples),
        .num_epochs  (num_epochs),
        .mem_ena     (mem_ena),
        .wr_rd       (wr_rd),
        .addr        (addr),
        .x1_rdata    (x1_rdata),
        .x2_rdata    (x2_rdata),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_x1        (s_x1),
        .s_x2        (s_x2),
        .s_idx       (s_idx),
        .s_last      (s_last),
        .s_epoch     (s_epoch),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: x1[i] = i*512, x2[i] = -i*512, one-cycle registered read.
    logic [15:0] x1_mem [1024];
    logic [15:0] x2_mem [1024];
    initial begin
        for (int i = 0; i < 1024; i++) begin
            x1_mem[i] = 16'(i * 512);
            x2_mem[i] = 16'(0 - i * 512);
        end
    end
    always @(posedge clk) begin
        if (mem_ena) begin
            x1_rdata <= x1_mem[addr[9:0]];
            x2_rdata <= x2_mem[addr[9:0]];
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        int ns;
        int ne;
        int rmode;      // 0: s_ready held 1, 1: s_ready toggles each cycle
        int exp_n;      // samples expected
        int exp_done;   // expected done cycle relative to start cycle, -1 = skip
        int exp_lat;    // expected last-pop minus first-issue cycle, -1 = skip
    } vec_t;

    // Called right after a posedge; returns right after a posedge.
    task automatic run_case(input string nm, input int ns, input int ne, input int rmode,
                            input int exp_n, input int exp_done, input int exp_lat);
        int ns_eff;
        int issued, popped, dones;
        int first_issue, first_valid, last_pop, done_cyc;
        int limit;
        bit hold;
        logic [51:0] held, act, expv;
        int eidx, eep;
        ns_eff = (ns > 1024) ? 1024 : ns;
        issued = 0; popped = 0; dones = 0;
        first_issue = -1; first_valid = -1; last_pop = -1; done_cyc = -1;
        hold = 1'b0; held = '0;
        limit = 4 * exp_n + 30;
        for (int c = 0; c < limit; c++) begin
            start       = (c == 0);
            num_samples = 11'(ns);
            num_epochs  = 8'(ne);
            s_ready     = (rmode == 0) ? 1'b1 : ((c % 2) == 1);
            @(negedge clk);
            act = {s_x1, s_x2, s_idx, s_last, s_epoch};
            if (hold) begin
                check($sformatf("%s_hold_c%0d", nm, c), {11'd0, s_valid, act}, {11'd0, 1'b1, held});
                hold = 1'b0;
            end
            check($sformatf("%s_outstanding_c%0d", nm, c), 64'(issued - popped <= 2), 64'd1);
            if (mem_ena) begin
                check($sformatf("%s_addr%0d", nm, issued), 64'(addr),
                      (ns_eff == 0) ? 64'hFFFF : 64'(issued % ns_eff));
                if (first_issue < 0) first_issue = c;
                issued++;
            end
            if (s_valid && first_valid < 0) first_valid = c;
            if (s_valid && s_ready) begin
                eidx = (ns_eff == 0) ? 0 : popped % ns_eff;
                eep  = (ns_eff == 0) ? 0 : popped / ns_eff;
                expv = {16'(eidx * 512), 16'(0 - eidx * 512), 11'(eidx),
                        (eidx == ns_eff - 1), 8'(eep)};
                check($sformatf("%s_sample%0d", nm, popped), 64'(act), 64'(expv));
                popped++;
                last_pop = c;
            end
            if (s_valid && !s_ready) begin
                hold = 1'b1;
                held = act;
            end
            if (done) begin
                dones++;
                done_cyc = c;
            end
            @(posedge clk);
            #1;
            if (done_cyc >= 0 && c >= done_cyc + 2) break;
        end
        start   = 1'b0;
        s_ready = 1'b0;
        check({nm, "_samples"}, 64'(popped), 64'(exp_n));
        check({nm, "_reads"},   64'(issued), 64'(exp_n));
        check({nm, "_dones"},   64'(dones),  64'd1);
        if (exp_n > 0)     check({nm, "_first_valid"}, 64'(first_valid), 64'd2);
        if (exp_done >= 0) check({nm, "_done_cycle"},  64'(done_cyc), 64'(exp_done));
        if (exp_lat >= 0)  check({nm, "_latency"},     64'(last_pop - first_issue), 64'(exp_lat));
        $display("run %s ns=%0d ne=%0d ready_mode=%0d: reads=%0d samples=%0d done@%0d",
                 nm, ns, ne, rmode, issued, popped, done_cyc);
    endtask

    vec_t vecs [9];
    int   cnt;

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; s_ready = 1'b0;
        num_samples = '0; num_epochs = '0;

        vecs[0] = '{ns: 4,    ne: 2, rmode: 0, exp_n: 8,    exp_done: -1, exp_lat: -1};
        vecs[1] = '{ns: 4,    ne: 2, rmode: 1, exp_n: 8,    exp_done: -1, exp_lat: -1};
        vecs[2] = '{ns: 0,    ne: 2, rmode: 0, exp_n: 0,    exp_done: 2,  exp_lat: -1};
        vecs[3] = '{ns: 3,    ne: 0, rmode: 0, exp_n: 0,    exp_done: 2,  exp_lat: -1};
        vecs[4] = '{ns: 1,    ne: 1, rmode: 0, exp_n: 1,    exp_done: -1, exp_lat: -1};
        vecs[5] = '{ns: 1,    ne: 3, rmode: 1, exp_n: 3,    exp_done: -1, exp_lat: -1};
        vecs[6] = '{ns: 5,    ne: 2, rmode: 1, exp_n: 10,   exp_done: -1, exp_lat: -1};
        vecs[7] = '{ns: 1024, ne: 1, rmode: 0, exp_n: 1024, exp_done: -1, exp_lat: 1025};
        vecs[8] = '{ns: 1500, ne: 1, rmode: 0, exp_n: 1024, exp_done: -1, exp_lat: 1025};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_ctrl", {48'd0, mem_ena, wr_rd, addr, s_valid, busy, done},
              64'd0);
        check("reset_data", {s_x1, s_x2, s_idx, s_last, s_epoch}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table-driven runs
        for (int v = 0; v < 9; v++) begin
            run_case($sformatf("vec%0d", v), vecs[v].ns, vecs[v].ne, vecs[v].rmode,
                     vecs[v].exp_n, vecs[v].exp_done, vecs[v].exp_lat);
            repeat (2) @(posedge clk);
            #1;
        end

        // Abort while the 3rd sample is presented and the buffer is full
        num_samples = 11'd4;
        num_epochs  = 8'd2;
        for (int c = 0; c <= 5; c++) begin
            start   = (c == 0);
            s_ready = (c < 4);
            abort   = (c == 5);
            @(negedge clk);
            if (c == 5) check("abort_pre_sample", {s_valid, s_idx, s_epoch}, {1'b1, 11'd2, 8'd0});
            @(posedge clk);
            #1;
        end
        abort = 1'b0; start = 1'b0; s_ready = 1'b0;
        @(negedge clk);
        check("abort_flushed", {61'd0, s_valid, busy, mem_ena}, 64'd0);
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || mem_ena || busy) cnt++;
        end
        check("abort_quiet", 64'(cnt), 64'd0);
        @(posedge clk);
        #1;
        $display("seq abort: quiet_cycles_violated=%0d", cnt);
        run_case("restart", 4, 1, 0, 4, -1, -1);

        // start and abort together: abort wins
        start = 1'b1; abort = 1'b1;
        num_samples = 11'd4; num_epochs = 8'd1;
        @(negedge clk);
        check("start_abort_mem_ena", 64'(mem_ena), 64'd0);
        @(posedge clk);
        #1;
        start = 1'b0; abort = 1'b0;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || mem_ena || busy) cnt++;
        end
        check("start_abort_idle", 64'(cnt), 64'd0);
        $display("seq start+abort: active_cycles=%0d", cnt);
        @(posedge clk);
        #1;

        // rst pulsed mid-run
        num_samples = 11'd4; num_epochs = 8'd2; s_ready = 1'b1;
        for (int c = 0; c <= 4; c++) begin
            start = (c == 0);
            rst   = (c == 4);
            @(posedge clk);
            #1;
        end
        rst = 1'b0; start = 1'b0; s_ready = 1'b0;
        @(negedge clk);
        check("midrst_ctrl", {48'd0, mem_ena, wr_rd, addr, s_valid, busy, done}, 64'd0);
        check("midrst_data", {s_x1, s_x2, s_idx, s_last, s_epoch}, 64'd0);
        $display("seq mid-run reset: busy=%0b s_valid=%0b", busy, s_valid);
        @(posedge clk);
        #1;
        run_case("post_rst", 3, 1, 0, 3, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sample_seq.md
SAMPLE_SEQ -- requirements
Module: sample_seq

Interface
REQ-001 Parameter DATA_W, default 16, sample width (Q6.9 fixed point, value = real*512).
REQ-002 Parameter ADDR_W, default 11, sample memory address width.
REQ-003 Parameter DEPTH, default 1024, number of valid memory locations.
REQ-004 Ports SHALL be, one per line: name direction width meaning.
REQ-005 clk  in  1  single clock; all logic on posedge clk.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 start  in  1  one-cycle pulse; begins a run when in IDLE, ignored otherwise.
REQ-008 abort  in  1  terminates the run and returns to IDLE.
REQ-009 num_samples  in  ADDR_W  samples per epoch, 0..DEPTH, sampled on start.
REQ-010 num_epochs  in  8  epochs per run, 0..255, sampled on start.
REQ-011 mem_ena  out  1  memory enable to both x1 and x2 memories.
REQ-012 wr_rd  out  1  memory write/read select; held 0 (read only).
REQ-013 addr  out  ADDR_W  shared read address for both memories.
REQ-014 x1_rdata, x2_rdata  in  DATA_W each  memory read data, valid one cycle after the mem_ena read.
REQ-015 s_valid / s_ready  out/in  1/1  output sample handshake.
REQ-016 s_x1, s_x2  out  DATA_W each  output sample pair.
REQ-017 s_idx  out  ADDR_W  sample index; s_last out 1, final sample of an epoch; s_epoch out 8, current epoch.
REQ-018 busy  out  1  high in any state other than IDLE; done out 1, one-cycle pulse at run completion.

Function
REQ-019 The FSM SHALL have states IDLE, RUN, DRAIN, DONE.
REQ-020 IDLE->RUN on start when num_samples!=0 and num_epochs!=0; IDLE->DONE on start otherwise.
REQ-021 In RUN, a read SHALL be issued (mem_ena=1) only when buffered + in-flight - pop_this_cycle < 2.
REQ-022 Read addresses SHALL run 0..num_samples-1 and wrap to 0 at each epoch boundary.
REQ-023 RUN->DRAIN after the final read of the final epoch is issued.
REQ-024 DRAIN->DONE when the buffer is empty and no read is in flight.
REQ-025 DONE SHALL pulse done for exactly one cycle and then move to IDLE.
REQ-026 Read data SHALL be captured into a 2-entry FIFO one cycle after issue, tagged with idx, last and epoch.
REQ-027 s_valid=1 whenever the FIFO is non-empty; a pop SHALL occur iff s_valid & s_ready.
REQ-028 s_x1/s_x2/s_idx/s_last/s_epoch SHALL remain stable while s_valid=1 and s_ready=0.
REQ-029 Sustained throughput with s_ready=1 SHALL be one sample per cycle; first s_valid appears 2 cycles after start.
REQ-030 Sample order SHALL be strictly in address order; no sample is dropped or duplicated.
REQ-031 abort SHALL force IDLE on the next edge from any state, flush the FIFO, discard in-flight data, and suppress done.
REQ-032 If start and abort are asserted together, abort SHALL win.
REQ-033 num_samples > DEPTH SHALL be clamped to DEPTH.

Reset
REQ-034 On rst: state=IDLE, mem_ena=0, wr_rd=0, addr=0, s_valid=0, s_x1=s_x2=0, s_idx=0, s_last=0, s_epoch=0, busy=0, done=0, FIFO empty.
REQ-035 rst asserted mid-run SHALL behave as abort, and additionally zero all registered outputs.

Structure
REQ-036 Package sample_seq_pkg SHALL hold DATA_W, ADDR_W, DEPTH, and the state enum typedef.
REQ-037 The 2-entry tagged buffer SHALL be the sub-module sample_seq_fifo2; all other logic SHALL be flat.

Verification
REQ-038 Memory model preloaded with x1[i]=i*512 and x2[i]=-i*512; start with num_samples=4 and num_epochs=2, s_ready=1 -> 8 samples, idx 0,1,2,3,0,1,2,3, s_last on idx 3, s_epoch 0 then 1, a single done pulse.
REQ-039 Same run with s_ready toggling every other cycle -> identical sample sequence, held outputs stable while stalled, and no more than 2 reads outstanding.
REQ-040 start with num_samples=0 (and separately num_epochs=0) -> mem_ena never asserted, done pulse 2 cycles after start.
REQ-041 abort asserted during the 3rd sample with the FIFO full -> s_valid=0 next cycle, no done pulse, and a new start restarts at idx 0 epoch 0.
REQ-042 num_samples=1024, num_epochs=1 -> addr reaches 1023, s_last at idx 1023, 1024 samples delivered in 1025 cycles after first issue.
REQ-043 rst pulsed mid-run -> all outputs at their reset values on the following cycle.
